if_fetch_queue: RTL

//  Instruction-fetch front end sitting directly upstream of the IF/ID latch of the pipelined processor.
//  - Owns the PC and fetches 32-bit instruction words from the word-addressed instruction memory.
//  - Buffers fetched words with their NPC in a small FIFO and hands them to decode over valid/ready.
//  - Stops fetching after an HLT is fetched; restarts on a branch/jump redirect, which also flushes the queue.

---
 rtl/if_fetch_queue_if.sv | 38 +++
 rtl/if_fetch_queue.sv | 133 +++++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if : fetch-queue bus (memory side, decode side, redirect)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              ir_valid;
  logic [31:0]       ir_out;
  logic [31:0]       npc_out;
  logic              id_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halted;
  logic [CNT_W-1:0]  q_count;

  // master: the fetch queue itself; slave: memory, decode and branch unit
  modport master (
    output imem_req, imem_addr, ir_valid, ir_out, npc_out, halted, q_count,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_out, npc_out, halted, q_count,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue : PC owner + instruction FIFO feeding IF/ID (IFQ_BYPASS_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic             clk1,
  input  logic             rst,
  if_fetch_queue_if.master bus
);
  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [5:0]       HLT_OP = 6'b111111;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      ir_q  [DEPTH];
  logic [31:0]      npc_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        req;
  logic        accept;
  logic        push;
  logic        pop;
  logic        q_nonempty;
  logic        valid;
  logic [31:0] pc_next;

  assign pc_next    = pc + 32'd1;
  assign q_nonempty = (count != '0);

  // A full queue blocks the request even when decode pops the head this cycle.
  assign req    = (state == RUN) && (count < FULL) && !bus.redirect && !rst;
  assign accept = req && bus.imem_ack;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // req already excludes redirect, so a redirect cycle never bypasses.
  assign bypass      = !q_nonempty && accept;
  assign bypass_take = bypass && bus.id_ready;
  assign push        = accept && !bypass_take;
  assign valid       = !rst && (q_nonempty || bypass);

  always_comb begin
    bus.ir_out  = 32'd0;
    bus.npc_out = 32'd0;
    if (valid) begin
      bus.ir_out  = q_nonempty ? ir_q[rd_ptr]  : bus.imem_rdata;
      bus.npc_out = q_nonempty ? npc_q[rd_ptr] : pc_next;
    end
  end
`else
  assign push  = accept;
  assign valid = !rst && q_nonempty;

  always_comb begin
    bus.ir_out  = 32'd0;
    bus.npc_out = 32'd0;
    if (valid) begin
      bus.ir_out  = ir_q[rd_ptr];
      bus.npc_out = npc_q[rd_ptr];
    end
  end
`endif

  assign pop = q_nonempty && valid && bus.id_ready && !bus.redirect;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc[ADDR_W-1:0];
  assign bus.ir_valid  = valid;
  assign bus.halted    = (state == HALT) && !rst;
  assign bus.q_count   = count;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect) begin
      state  <= RUN;
      pc     <= bus.redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (accept) begin
        pc <= pc_next;
        if (bus.imem_rdata[31:26] == HLT_OP) begin
          state <= HALT;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_q[wr_ptr]  <= bus.imem_rdata;
      npc_q[wr_ptr] <= pc_next;
    end
  end

endmodule

`default_nettype wire
